// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART serial transmitter
//
// Accepts a byte on a level-sensitive txStart/txData handshake while idle and
// serialises it onto an idle-high line: one start bit (0), eight data bits LSB
// first, an optional parity bit, then one or two stop bits (1). Every bit is
// held for CLKS_PER_BIT clock cycles. All outputs are registered.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   txStart  request to send txData; sampled only while idle
//   txData   byte to send; captured on the accepting edge
//   txBusy   high from acceptance until the last stop bit ends
//   tx       serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txStart,
    input  logic [7:0] txData,
    output logic       txBusy,
    output logic       tx
);

    // Counter width follows $clog2(CLKS_PER_BIT); the guard only keeps an
    // illegal CLKS_PER_BIT from producing a zero-width vector.
    localparam int CW = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_data;
    logic            r_tx;
    logic            r_busy;
    logic            w_bit_end;

    // Parity bit for the latched byte: odd parity inverts the XOR reduction.
    function automatic logic parity_bit(input logic [7:0] d);
        if (PARITY == 1) begin
            return ~^d;
        end else begin
            return ^d;
        end
    endfunction

    // Elaboration-time parameter legality checks.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx: CLKS_PER_BIT must be >= 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    assign w_bit_end = (r_clk_cnt == CNT_MAX);

    // Frame sequencer: state, bit timing, shift data and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= CNT_ZERO;
            r_bit_idx <= 3'd0;
            r_data    <= 8'h00;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                    r_clk_cnt <= CNT_ZERO;
                    r_bit_idx <= 3'd0;
                    if (txStart) begin
                        // Start bit is driven from this edge, so the line
                        // falls one cycle after txStart is sampled.
                        r_data  <= txData;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= CNT_ZERO;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_data[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= CNT_ZERO;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            if (PARITY != 0) begin
                                r_tx    <= parity_bit(r_data);
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_data[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end

                S_PARITY: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= CNT_ZERO;
                        r_bit_idx <= 3'd0;
                        r_tx      <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end

                S_STOP: begin
                    // The bit index is reused to count stop bits.
                    if (w_bit_end) begin
                        r_clk_cnt <= CNT_ZERO;
                        if (r_bit_idx == STOP_LAST) begin
                            r_bit_idx <= 3'd0;
                            r_busy    <= 1'b0;
                            r_tx      <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= CNT_ZERO;
                    r_bit_idx <= 3'd0;
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign txBusy = r_busy;
    assign tx     = r_tx;

endmodule
